// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM state encodings
// and the misalignment predicate.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds the FAULT state and the trap check).
package load_store_unit_pkg;

    // RISC-V funct3 access-size codes; 3, 6 and 7 are decoded as word everywhere.
    localparam logic [2:0] LSU_SIZE_B  = 3'd0,
                           LSU_SIZE_H  = 3'd1,
                           LSU_SIZE_W  = 3'd2,
                           LSU_SIZE_BU = 3'd4,
                           LSU_SIZE_HU = 3'd5;

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } lsu_state_e;

    // Halfwords must be 2-byte aligned, words (including the aliased codes) 4-byte aligned.
    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            LSU_SIZE_B, LSU_SIZE_BU: return 1'b0;
            LSU_SIZE_H, LSU_SIZE_HU: return lo[0];
            default:                 return (lo != 2'b00);
        endcase
    endfunction
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;
`endif

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side and memory-side signals of the load/store unit, bundled as one interface.
// slave: the LSU's view; master: the environment (core + memory) driving it.
// Address width follows the ADDR_W parameter of the instance.
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              core_req;
    logic              core_we;
    logic [2:0]        core_size;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wd;
    logic [31:0]       core_rd;
    logic              core_stall;
    logic              core_misalign;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;
    logic              mem_ready;

    modport slave (
        input  core_req, core_we, core_size, core_addr, core_wd, mem_rd, mem_ready,
        output core_rd, core_stall, core_misalign, mem_req, mem_we, mem_be, mem_addr, mem_wd
    );

    modport master (
        output core_req, core_we, core_size, core_addr, core_wd, mem_rd, mem_ready,
        input  core_rd, core_stall, core_misalign, mem_req, mem_we, mem_be, mem_addr, mem_wd
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: byte enables and store replication for a request, lane
// extraction plus sign/zero extension for a load response.
// Purely combinational, no handshake.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_size_i,
    input  logic [1:0]  st_lo_i,
    input  logic [31:0] st_wd_i,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_lo_i,
    input  logic [31:0] ld_raw_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wd_o,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request side: halfwords look only at addr[1], so a stray addr[0] is dropped here.
    always_comb begin
        st_be_o = 4'b1111;
        st_wd_o = st_wd_i;
        case (st_size_i)
            LSU_SIZE_B, LSU_SIZE_BU: begin
                st_be_o = 4'b0001 << st_lo_i;
                st_wd_o = {4{st_wd_i[7:0]}};
            end
            LSU_SIZE_H, LSU_SIZE_HU: begin
                st_be_o = 4'b0011 << {st_lo_i[1], 1'b0};
                st_wd_o = {2{st_wd_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Response side: pick the addressed lane, then extend according to signedness.
    always_comb begin
        case (ld_lo_i)
            2'd0:    ld_byte = ld_raw_i[7:0];
            2'd1:    ld_byte = ld_raw_i[15:8];
            2'd2:    ld_byte = ld_raw_i[23:16];
            default: ld_byte = ld_raw_i[31:24];
        endcase
        ld_half = ld_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
        case (ld_size_i)
            LSU_SIZE_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LSU_SIZE_BU: ld_data_o = {24'd0, ld_byte};
            LSU_SIZE_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            LSU_SIZE_HU: ld_data_o = {16'd0, ld_half};
            default:     ld_data_o = ld_raw_i;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into one word-aligned bus transaction.
// Latency 3 cycles (IDLE, REQ, DONE) plus one per mem_ready wait cycle.
// Stalls the core while accepting and while the bus request is outstanding.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses fault instead of aligning down).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        size_q;
    logic [1:0]        addr_lo_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wd_q;
    logic [31:0]       core_rd_q;
    logic [3:0]        st_be_d;
    logic [31:0]       st_wd_d;
    logic [31:0]       core_rd_d;

    lsu_lane_align u_lane_align (
        .st_size_i (bus.core_size),
        .st_lo_i   (bus.core_addr[1:0]),
        .st_wd_i   (bus.core_wd),
        .ld_size_i (size_q),
        .ld_lo_i   (addr_lo_q),
        .ld_raw_i  (bus.mem_rd),
        .st_be_o   (st_be_d),
        .st_wd_o   (st_wd_d),
        .ld_data_o (core_rd_d)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign bus.core_misalign = misalign_q;
`else
    assign bus.core_misalign = 1'b0;
`endif

    // Access sequencer with registered bus outputs; the bus fields are loaded once on
    // acceptance so they stay stable for however long mem_ready is withheld.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 3'd0;
            addr_lo_q  <= 2'd0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'd0;
            mem_addr_q <= '0;
            mem_wd_q   <= 32'd0;
            core_rd_q  <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.core_req) begin
                        we_q      <= bus.core_we;
                        size_q    <= bus.core_size;
                        addr_lo_q <= bus.core_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
                        if (lsu_misaligned(bus.core_size, bus.core_addr[1:0])) begin
                            state_q    <= FAULT;
                            misalign_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q    <= REQ;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= bus.core_we;
                            mem_be_q   <= st_be_d;
                            mem_addr_q <= {bus.core_addr[ADDR_W-1:2], 2'b00};
                            mem_wd_q   <= st_wd_d;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (!we_q) begin
                            core_rd_q <= core_rd_d;
                        end
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall is combinational so the core freezes in the very cycle it issues the access.
    assign bus.core_stall = !rst && ((bus.core_req && (state_q == IDLE)) || (state_q == REQ));

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_be   = mem_be_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign bus.core_rd  = core_rd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset values, store/load lane steering,
// wait states, misaligned handling (both builds) and reset during a transaction.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_store_unit_if #(.ADDR_W(32)) bus_if ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations gathered by run_access.
    int          lat;
    int          nreq;
    int          nmis;
    bit          stable;
    logic [3:0]  be_s;
    logic [31:0] addr_s;
    logic [31:0] wd_s;
    logic        we_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access right after a rising edge, hold it until stall drops, let the
    // memory answer after wait_n extra REQ cycles, then release the request.
    task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int wait_n);
        bit done;
        bus_if.core_req  = 1'b1;
        bus_if.core_we   = we;
        bus_if.core_size = size;
        bus_if.core_addr = addr;
        bus_if.core_wd   = wd;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rd    = 32'hA5A5_A5A5;
        lat = 0; nreq = 0; nmis = 0; stable = 1'b1; done = 1'b0;
        be_s = 4'hx; addr_s = 32'hx; wd_s = 32'hx; we_s = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (bus_if.core_misalign) nmis++;
            if (bus_if.mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    be_s = bus_if.mem_be; addr_s = bus_if.mem_addr;
                    wd_s = bus_if.mem_wd; we_s = bus_if.mem_we;
                end else if (bus_if.mem_be !== be_s || bus_if.mem_addr !== addr_s ||
                             bus_if.mem_wd !== wd_s || bus_if.mem_we !== we_s) begin
                    stable = 1'b0;
                end
            end
            if (!bus_if.core_stall) begin
                done = 1'b1;
                bus_if.mem_ready = 1'b0;
                bus_if.mem_rd    = 32'hA5A5_A5A5;
            end else begin
                bus_if.mem_ready = (nreq > wait_n);
                bus_if.mem_rd    = bus_if.mem_ready ? rdata : 32'hA5A5_A5A5;
            end
        end
        @(posedge clk); #1;
        bus_if.core_req  = 1'b0;
        bus_if.mem_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.core_req  = 1'b1;
        bus_if.core_we   = 1'b1;
        bus_if.core_size = 3'd2;
        bus_if.core_addr = 32'h0000_0040;
        bus_if.core_wd   = 32'h1111_1111;
        bus_if.mem_rd    = 32'h2222_2222;
        bus_if.mem_ready = 1'b1;

        // Reset state, with a request pending to show stall is suppressed.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req",  bus_if.mem_req, 0);
        chk("rst_mem_we",   bus_if.mem_we, 0);
        chk("rst_mem_be",   bus_if.mem_be, 0);
        chk("rst_mem_addr", bus_if.mem_addr, 0);
        chk("rst_mem_wd",   bus_if.mem_wd, 0);
        chk("rst_core_rd",  bus_if.core_rd, 0);
        chk("rst_misalign", bus_if.core_misalign, 0);
        chk("rst_stall",    bus_if.core_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.core_req  = 1'b0;
        bus_if.mem_ready = 1'b0;
        @(posedge clk); #1;

        // SW word, immediate ready.
        run_access(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
        chk("sw_lat",  lat, 3);
        chk("sw_nreq", nreq, 1);
        chk("sw_we",   we_s, 1);
        chk("sw_be",   be_s, 4'b1111);
        chk("sw_addr", addr_s, 32'h0000_0100);
        chk("sw_wd",   wd_s, 32'hDEAD_BEEF);
        chk("sw_rd_untouched", bus_if.core_rd, 0);

        // LB / LBU from the top byte.
        run_access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        chk("lb_be",   be_s, 4'b1000);
        chk("lb_addr", addr_s, 32'h0000_0100);
        chk("lb_rd",   bus_if.core_rd, 32'hFFFF_FF80);
        run_access(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        chk("lbu_rd",  bus_if.core_rd, 32'h0000_0080);

        // LB positive byte in lane 1.
        run_access(1'b0, 3'd0, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0);
        chk("lb1_be", be_s, 4'b0010);
        chk("lb1_rd", bus_if.core_rd, 32'h0000_007F);

        // LH upper half, then SH replicates and leaves core_rd alone.
        run_access(1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h8001_1234, 0);
        chk("lh_be", be_s, 4'b1100);
        chk("lh_rd", bus_if.core_rd, 32'hFFFF_8001);
        run_access(1'b1, 3'd1, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0);
        chk("sh_be", be_s, 4'b1100);
        chk("sh_wd", wd_s, 32'hABCD_ABCD);
        chk("sh_rd_untouched", bus_if.core_rd, 32'hFFFF_8001);

        // LHU lower half; SB lane 1 replicates the low byte.
        run_access(1'b0, 3'd5, 32'h0000_0100, 32'h0, 32'h8001_9234, 0);
        chk("lhu_be", be_s, 4'b0011);
        chk("lhu_rd", bus_if.core_rd, 32'h0000_9234);
        run_access(1'b1, 3'd0, 32'h0000_0101, 32'h1234_5678, 32'h0, 0);
        chk("sb_be", be_s, 4'b0010);
        chk("sb_wd", wd_s, 32'h7878_7878);

        // LW with five wait cycles.
        run_access(1'b0, 3'd2, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 5);
        chk("lw_wait_lat",    lat, 8);
        chk("lw_wait_nreq",   nreq, 6);
        chk("lw_wait_stable", stable, 1);
        chk("lw_wait_addr",   addr_s, 32'h0000_0200);
        chk("lw_wait_rd",     bus_if.core_rd, 32'hCAFE_F00D);

        // Reserved size codes behave as word.
        run_access(1'b1, 3'd7, 32'h0000_0104, 32'h0102_0304, 32'h0, 0);
        chk("sz7_be", be_s, 4'b1111);
        chk("sz7_wd", wd_s, 32'h0102_0304);
        run_access(1'b0, 3'd3, 32'h0000_0108, 32'h0, 32'h8765_4321, 0);
        chk("sz3_rd", bus_if.core_rd, 32'h8765_4321);

        // Misaligned word.
        run_access(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lat",  lat, 2);
        chk("mis_nreq", nreq, 0);
        chk("mis_pulse", nmis, 1);
        chk("mis_rd_untouched", bus_if.core_rd, 32'h8765_4321);
        @(negedge clk);
        chk("mis_pulse_end", bus_if.core_misalign, 0);
        chk("mis_no_req", bus_if.mem_req, 0);
`else
        chk("mis_lat",   lat, 3);
        chk("mis_addr",  addr_s, 32'h0000_0100);
        chk("mis_be",    be_s, 4'b1111);
        chk("mis_pulse", nmis, 0);
        chk("mis_rd",    bus_if.core_rd, 32'h1357_9BDF);
`endif

        // Reset while a load is outstanding; a late ready must be ignored.
        @(posedge clk); #1;
        bus_if.core_req  = 1'b1;
        bus_if.core_we   = 1'b0;
        bus_if.core_size = 3'd2;
        bus_if.core_addr = 32'h0000_0300;
        bus_if.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_in_req", bus_if.mem_req, 1);
        rst = 1'b1;
        bus_if.core_req = 1'b0;
        @(negedge clk);
        chk("midrst_req_drop", bus_if.mem_req, 0);
        chk("midrst_rd_clear", bus_if.core_rd, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rd    = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("late_ready_rd",    bus_if.core_rd, 0);
        chk("late_ready_req",   bus_if.mem_req, 0);
        chk("late_ready_stall", bus_if.core_stall, 0);
        bus_if.mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
